xpb_lookup_seq: RTL and testbench
=================================

XPB_LOOKUP_SEQ -- requirements
Module: xpb_lookup_seq

Interface
REQ-001 SHALL have parameter NUM_SEG, default 8: number of 5-bit segments reduced per job.
REQ-002 SHALL have parameter SEG_W, default 5: segment width, equal to the xpb table address width.
REQ-003 SHALL have parameter WORD_W, default 1024: xpb table entry width.
REQ-004 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port start, input, 1: job request, sampled only in IDLE.
REQ-007 SHALL have port seg_vec, input, NUM_SEG*SEG_W: segment i occupies bits [i*SEG_W +: SEG_W]; captured on start acceptance.
REQ-008 SHALL have port busy, output, 1: high from start acceptance until done.
REQ-009 SHALL have port done, output, 1: one-cycle completion pulse.
REQ-010 SHALL have port rom_en, output, 1: a table lookup is issued this cycle.
REQ-011 SHALL have port rom_sel, output, clog2(NUM_SEG): selects the xpb table for segment position i.
REQ-012 SHALL have port rom_addr, output, SEG_W: table address, equal to segment i.
REQ-013 SHALL have port rom_data, input, WORD_W: table output, registered, valid one cycle after rom_en.
REQ-014 SHALL have port acc_out, output, WORD_W+clog2(NUM_SEG): sum of all looked-up entries.

Function
REQ-015 SHALL implement FSM states IDLE, ISSUE, DRAIN, DONE.
REQ-016 IDLE with start=1 at edge t0 SHALL:
- capture seg_vec;
- clear the accumulator;
- set busy;
- enter ISSUE at index 0 (REQ-029 governs when the macro is defined).
REQ-017 In ISSUE, each cycle SHALL drive rom_en=1, rom_sel=index and rom_addr=segment[index], then advance the index by one.
REQ-018 After issuing index NUM_SEG-1, the FSM SHALL go to DRAIN; DRAIN SHALL last exactly one cycle, then go to DONE.
REQ-019 A registered copy of rom_en (valid_d) SHALL gate accumulation; on each edge with valid_d=1, acc SHALL become acc + rom_data.
REQ-020 Accumulator arithmetic SHALL be exact, with no truncation; the width WORD_W+clog2(NUM_SEG) holds NUM_SEG maximal entries.
REQ-021 DONE SHALL last one cycle with done=1 and busy=0, then return to IDLE.
REQ-022 With k lookups issued, done SHALL be high in the cycle after k+1 edges following t0; default is k=8, giving 9 edges.
REQ-023 acc_out SHALL be final when done=1 and SHALL hold that value until the next accepted start.
REQ-024 start SHALL be ignored while busy=1 or during DONE; seg_vec changes after capture SHALL have no effect.
REQ-025 Outside ISSUE, rom_en SHALL be 0, rom_sel SHALL be 0 and rom_addr SHALL be 0.

Reset
REQ-026 reset=1 SHALL immediately force:
- state to IDLE;
- busy, done, rom_en and valid_d to 0;
- index, rom_sel and rom_addr to 0;
- acc_out to 0.
REQ-027 Reset asserted mid-job SHALL abandon the job with no done pulse; the first start after release SHALL behave as from power-up.

Configuration
REQ-028 Macro XPB_SKIP_ZERO_EN SHALL control zero-segment skipping.
REQ-029 With XPB_SKIP_ZERO_EN defined:
- ISSUE SHALL visit only nonzero segments, in ascending index order, jumping to the next nonzero one by priority search;
- zero segments SHALL consume no cycle and no lookup;
- if all segments are zero, t0 SHALL go directly to DRAIN;
- k SHALL equal the nonzero count, with REQ-022 still holding.
REQ-030 Without XPB_SKIP_ZERO_EN, every segment SHALL be issued, including zeros (k=NUM_SEG), and no priority logic SHALL exist.

Verification
Bench ROM model: rom_data = (rom_sel+1)*rom_addr, returned one cycle after rom_en.
REQ-031 All segments 5'h1f, start -> 8 lookups at sel 0..7; done 9 edges after t0; acc_out = 36*31 = 1116.
REQ-032 Model forced to all-ones WORD_W for every access, all segments nonzero -> acc_out = 8*(2^1024-1), with no bit lost.
REQ-033 start held high through the job, seg_vec changed mid-job -> exactly one done; result uses the captured seg_vec; the next job starts only after return to IDLE.
REQ-034 reset pulsed at the 4th ISSUE cycle -> all outputs 0 at once, no done; a new job with segments 1..8 gives acc_out = sum((i+1)*(i+1)) over i=0..7 = 204.
REQ-035 Only segment 3 = 5'h02 nonzero -> macro defined: one lookup (sel 3, addr 2), done after 2 edges, acc_out=8; macro undefined: 8 lookups, done after 9 edges, acc_out=8.
REQ-036 All segments zero with macro defined -> rom_en never high, done after 1 edge, acc_out=0.

Source files
------------

// File: rtl/xpb_lookup_seq.sv
// Issues one xpb table lookup per segment and sums the returned entries exactly.
// Optional build macro XPB_SKIP_ZERO_EN: zero segments are skipped (no lookup, no cycle).
module xpb_lookup_seq #(
    parameter int NUM_SEG = 8,
    parameter int SEG_W   = 5,
    parameter int WORD_W  = 1024,
    localparam int SEL_W  = $clog2(NUM_SEG),
    localparam int ACC_W  = WORD_W + SEL_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [NUM_SEG*SEG_W-1:0] seg_vec,
    output logic                     busy,
    output logic                     done,
    output logic                     rom_en,
    output logic [SEL_W-1:0]         rom_sel,
    output logic [SEG_W-1:0]         rom_addr,
    input  logic [WORD_W-1:0]        rom_data,
    output logic [ACC_W-1:0]         acc_out
);

    // state | meaning
    // IDLE  | waiting for start; acc_out holds the last result
    // ISSUE | one table lookup per cycle, rom_sel is the current segment index
    // DRAIN | last lookup's data returns and is accumulated
    // DONE  | one-cycle done pulse, busy already low
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t           state;
    logic             valid_d;
    logic [SEG_W-1:0] seg_in [NUM_SEG];
    logic [SEG_W-1:0] seg_q  [NUM_SEG];
    logic             first_ok;
    logic [SEL_W-1:0] first_idx;
    logic             next_ok;
    logic [SEL_W-1:0] next_idx;

    always_comb begin
        for (int i = 0; i < NUM_SEG; i++) begin
            seg_in[i] = seg_vec[i*SEG_W +: SEG_W];
        end
    end

`ifdef XPB_SKIP_ZERO_EN
    // Priority search: lowest nonzero index overall, and lowest nonzero index above rom_sel.
    always_comb begin
        first_ok  = 1'b0;
        first_idx = '0;
        next_ok   = 1'b0;
        next_idx  = '0;
        for (int i = NUM_SEG - 1; i >= 0; i--) begin
            if (seg_in[i] != '0) begin
                first_ok  = 1'b1;
                first_idx = SEL_W'(i);
            end
            if (seg_q[i] != '0 && i > int'(rom_sel)) begin
                next_ok  = 1'b1;
                next_idx = SEL_W'(i);
            end
        end
    end
`else
    assign first_ok  = 1'b1;
    assign first_idx = '0;
    assign next_ok   = (rom_sel != SEL_W'(NUM_SEG - 1));
    assign next_idx  = rom_sel + SEL_W'(1);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            rom_en   <= 1'b0;
            valid_d  <= 1'b0;
            rom_sel  <= '0;
            rom_addr <= '0;
            acc_out  <= '0;
            seg_q    <= '{default: '0};
        end else begin
            valid_d <= rom_en;
            done    <= 1'b0;
            if (valid_d) begin
                acc_out <= acc_out + {{SEL_W{1'b0}}, rom_data};
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        seg_q   <= seg_in;
                        acc_out <= '0;
                        busy    <= 1'b1;
                        if (first_ok) begin
                            state    <= ISSUE;
                            rom_en   <= 1'b1;
                            rom_sel  <= first_idx;
                            rom_addr <= seg_in[first_idx];
                        end else begin
                            state <= DRAIN;
                        end
                    end
                end
                ISSUE: begin
                    if (next_ok) begin
                        rom_sel  <= next_idx;
                        rom_addr <= seg_q[next_idx];
                    end else begin
                        state    <= DRAIN;
                        rom_en   <= 1'b0;
                        rom_sel  <= '0;
                        rom_addr <= '0;
                    end
                end
                DRAIN: begin
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_xpb_lookup_seq.sv
// Scoreboard bench for xpb_lookup_seq: stimulus pushes expected lookups and results,
// a negedge monitor pops and compares them as the DUT presents rom_en and done.
module tb_xpb_lookup_seq;

    localparam int NUM_SEG = 8;
    localparam int SEG_W   = 5;
    localparam int WORD_W  = 1024;
    localparam int SEL_W   = 3;
    localparam int ACC_W   = WORD_W + SEL_W;
    localparam int SV_W    = NUM_SEG * SEG_W;
`ifdef XPB_SKIP_ZERO_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic [SV_W-1:0]   seg_vec = '0;
    logic              busy;
    logic              done;
    logic              rom_en;
    logic [SEL_W-1:0]  rom_sel;
    logic [SEG_W-1:0]  rom_addr;
    logic [WORD_W-1:0] rom_data = '0;
    logic [ACC_W-1:0]  acc_out;

    typedef struct {
        logic [SEL_W-1:0] sel;
        logic [SEG_W-1:0] addr;
    } lk_t;
    typedef struct {
        logic [ACC_W-1:0] acc;
        int               done_cyc;
    } job_t;

    lk_t              lk_q[$];
    job_t             job_q[$];
    lk_t              mon_l;
    job_t             mon_j;
    int               checks = 0;
    int               errors = 0;
    int               cyc = 0;
    logic             force_ones = 1'b0;
    logic [ACC_W-1:0] last_acc = '0;
    logic [SV_W-1:0]  segs;

    xpb_lookup_seq #(.NUM_SEG(NUM_SEG), .SEG_W(SEG_W), .WORD_W(WORD_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .seg_vec  (seg_vec),
        .busy     (busy),
        .done     (done),
        .rom_en   (rom_en),
        .rom_sel  (rom_sel),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .acc_out  (acc_out)
    );

    always #5 clk = ~clk;

    // Table model: entry (sel+1)*addr, or all ones when forced, one cycle after rom_en.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rom_en) begin
            rom_data <= force_ones ? {WORD_W{1'b1}} : WORD_W'((int'(rom_sel) + 1) * int'(rom_addr));
        end
    end

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic check_acc(input string name, input logic [ACC_W-1:0] act, input logic [ACC_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference: every segment (or every nonzero one when skipping) is looked up in index order.
    task automatic push_job(input logic [SV_W-1:0] s_vec);
        job_t             j;
        lk_t              l;
        logic [SEG_W-1:0] s;
        int               k;
        k     = 0;
        j.acc = '0;
        for (int i = 0; i < NUM_SEG; i++) begin
            s = s_vec[i*SEG_W +: SEG_W];
            if (!(SKIP && s == '0)) begin
                l.sel  = SEL_W'(i);
                l.addr = s;
                lk_q.push_back(l);
                k++;
                j.acc = j.acc + (force_ones ? ACC_W'({WORD_W{1'b1}}) : ACC_W'((i + 1) * int'(s)));
            end
        end
        j.done_cyc = cyc + k + 2;
        job_q.push_back(j);
        last_acc = j.acc;
    endtask

    function automatic logic [SV_W-1:0] rand_segs(input int zero_pct);
        logic [SV_W-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_SEG; i++) begin
            v[i*SEG_W +: SEG_W] = (int'($urandom_range(0, 99)) < zero_pct) ? '0 : SEG_W'($urandom_range(1, 31));
        end
        return v;
    endfunction

    task automatic wait_done(input bit wiggle);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 64 && !seen; n++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
            else if (wiggle) start = 1'($urandom_range(0, 1));
        end
        if (wiggle) start = 1'b0;
        check_int("done_seen", int'(seen), 1);
    endtask

    task automatic run_job(input logic [SV_W-1:0] s_vec, input bit wiggle);
        @(negedge clk);
        push_job(s_vec);
        seg_vec = s_vec;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        seg_vec = SV_W'({$urandom(), $urandom()});
        wait_done(wiggle);
        repeat (2) @(negedge clk);
        check_acc("acc_hold", acc_out, last_acc);
        check_int("busy_idle", int'(busy), 0);
    endtask

    task automatic check_all_zero(input string tag);
        check_int({tag, "_busy"}, int'(busy), 0);
        check_int({tag, "_done"}, int'(done), 0);
        check_int({tag, "_rom_en"}, int'(rom_en), 0);
        check_int({tag, "_rom_sel"}, int'(rom_sel), 0);
        check_int({tag, "_rom_addr"}, int'(rom_addr), 0);
        check_acc({tag, "_acc_out"}, acc_out, '0);
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (rom_en) begin
                checks++;
                if (lk_q.size() == 0) begin
                    errors++;
                    $display("FAIL lookup_extra sel=%0d addr=%0d expected no lookup", rom_sel, rom_addr);
                end else begin
                    mon_l = lk_q.pop_front();
                    check_int("lookup_sel", int'(rom_sel), int'(mon_l.sel));
                    check_int("lookup_addr", int'(rom_addr), int'(mon_l.addr));
                end
            end else begin
                check_int("quiet_sel_addr", int'({rom_sel, rom_addr}), 0);
            end
            if (done) begin
                checks++;
                if (job_q.size() == 0) begin
                    errors++;
                    $display("FAIL done_extra acc_out=%0h expected no done", acc_out);
                end else begin
                    mon_j = job_q.pop_front();
                    check_acc("result", acc_out, mon_j.acc);
                    check_int("done_latency", cyc, mon_j.done_cyc);
                    check_int("busy_in_done", int'(busy), 0);
                    check_int("lookups_consumed", lk_q.size(), 0);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "stopped by watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;

        run_job({NUM_SEG{5'h1f}}, 1'b0);

        segs = '0;
        segs[3*SEG_W +: SEG_W] = 5'h02;
        run_job(segs, 1'b0);

        run_job('0, 1'b0);

        force_ones = 1'b1;
        run_job(rand_segs(0), 1'b0);
        force_ones = 1'b0;

        // start held high through a job, inputs changed after capture
        @(negedge clk);
        segs = rand_segs(20);
        push_job(segs);
        seg_vec = segs;
        start   = 1'b1;
        repeat (3) @(negedge clk);
        seg_vec = rand_segs(20);
        wait_done(1'b0);
        @(negedge clk);
        check_int("busy_back_in_idle", int'(busy), 0);
        push_job(seg_vec);
        @(negedge clk);
        start   = 1'b0;
        seg_vec = rand_segs(20);
        wait_done(1'b0);
        repeat (2) @(negedge clk);

        // reset during the 4th issue cycle abandons the job
        @(negedge clk);
        segs = rand_segs(0);
        push_job(segs);
        seg_vec = segs;
        start   = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_int("issue4_rom_en", int'(rom_en), 1);
        check_int("issue4_rom_sel", int'(rom_sel), 3);
        reset = 1'b1;
        lk_q.delete();
        job_q.delete();
        #1;
        check_all_zero("async_reset");
        @(negedge clk);
        reset = 1'b0;

        segs = '0;
        for (int i = 0; i < NUM_SEG; i++) segs[i*SEG_W +: SEG_W] = SEG_W'(i + 1);
        run_job(segs, 1'b0);
        check_acc("after_reset_204", acc_out, ACC_W'(204));

        for (int r = 0; r < 12; r++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_job(rand_segs(30), 1'b1);
        end

        repeat (4) @(negedge clk);
        check_int("jobs_left", job_q.size(), 0);
        check_int("lookups_left", lk_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
